// File: rtl/video_pattern_timing_if.sv
// Video output bundle from the raster/pattern generator to the HDMI transmitter pins.
//   de, hsync, vsync, rgb[23:0], x[XW-1:0], y[YW-1:0], frame_start
//   master: the generator drives everything; slave: the transmitter side samples it.
interface video_pattern_timing_if #(
  parameter int unsigned XW = 11,
  parameter int unsigned YW = 10
);
  logic          de;
  logic          hsync;
  logic          vsync;
  logic [23:0]   rgb;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          frame_start;

  modport master (output de, output hsync, output vsync, output rgb,
                  output x, output y, output frame_start);
  modport slave  (input de, input hsync, input vsync, input rgb,
                  input x, input y, input frame_start);
endinterface

// File: rtl/video_pattern_timing.sv
// Parametrised raster timing and test-pattern generator (solid, colour bars,
// checker, gradient) for the ADV7513 HDMI path. All outputs are registered once
// and mutually aligned: each output cycle reflects the counters of the previous cycle.
// Ports:
//   pix_clk    pixel clock
//   reset      synchronous active-high reset
//   mode       pattern select (0 solid, 1 bars, 2 checker, 3 gradient), latched at (0,0)
//   solid_rgb  mode-0 colour {R,G,B}, latched at (0,0)
//   vid        video_pattern_timing_if master: de/hsync/vsync/rgb/x/y/frame_start
// Optional macro TPG_BORDER_EN: forces FFFFFF on the outer ring of active pixels.
module video_pattern_timing #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FP       = 110,
  parameter int unsigned H_SYNC     = 40,
  parameter int unsigned H_BP       = 220,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned V_FP       = 5,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 20,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned CHECK_LOG2 = 4
) (
  input  logic                   pix_clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [23:0]            solid_rgb,
  video_pattern_timing_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW      = $clog2(H_TOTAL);
  localparam int unsigned YW      = $clog2(V_TOTAL);
  localparam int unsigned BW      = H_ACTIVE / 8;
  localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
  localparam int unsigned HS_HI   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
  localparam int unsigned VS_HI   = V_ACTIVE + V_FP + V_SYNC;

  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [23:0]   rgb_q, rgb_d;

  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [23:0]   pix_q, pix_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          fs_q, fs_d;

  logic [31:0]   h32, v32;
  logic          origin, h_last, v_last;
  logic          h_act, v_act;
  logic [2:0]    bar_idx;
  logic          chk_bit;
  logic [7:0]    grad;
  logic [23:0]   pat;

  // Counters, frame-latched pattern registers and next output values.
  always_comb begin
    h32     = 32'(h_cnt_q);
    v32     = 32'(v_cnt_q);
    origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
    h_last  = (h32 == H_TOTAL - 1);
    v_last  = (v32 == V_TOTAL - 1);

    h_cnt_d = h_last ? '0 : h_cnt_q + XW'(1);
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + YW'(1);
    end

    // At (0,0) the fresh inputs are used directly so the first pixel of the
    // frame already shows the newly selected pattern.
    mode_d  = origin ? mode      : mode_q;
    rgb_d   = origin ? solid_rgb : rgb_q;

    h_act   = (h32 < H_ACTIVE);
    v_act   = (v32 < V_ACTIVE);

    // Bar index from a comparator chain against constant bar edges; columns
    // past 8*BW fall into bar 7 because the chain stops at k=7.
    bar_idx = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (h32 >= k * BW) begin
        bar_idx = 3'(k);
      end
    end

    chk_bit = (((h32 >> CHECK_LOG2) ^ (v32 >> CHECK_LOG2)) & 32'd1) != 32'd0;
    grad    = h32[7:0];

    case (mode_d)
      2'd0: pat = rgb_d;
      2'd1: begin
        case (bar_idx)
          3'd0:    pat = 24'hFFFFFF;
          3'd1:    pat = 24'hFFFF00;
          3'd2:    pat = 24'h00FFFF;
          3'd3:    pat = 24'h00FF00;
          3'd4:    pat = 24'hFF00FF;
          3'd5:    pat = 24'hFF0000;
          3'd6:    pat = 24'h0000FF;
          default: pat = 24'h000000;
        endcase
      end
      2'd2:    pat = chk_bit ? 24'hFFFFFF : 24'h000000;
      default: pat = {grad, grad, grad};
    endcase

`ifdef TPG_BORDER_EN
    if ((h32 == 0) || (h32 == H_ACTIVE - 1) || (v32 == 0) || (v32 == V_ACTIVE - 1)) begin
      pat = 24'hFFFFFF;
    end
`endif

    de_d    = h_act && v_act;
    hsync_d = ((h32 >= HS_LO) && (h32 < HS_HI)) ? HS_POL : ~HS_POL;
    vsync_d = ((v32 >= VS_LO) && (v32 < VS_HI)) ? VS_POL : ~VS_POL;
    pix_d   = de_d ? pat : 24'h000000;
    x_d     = h_cnt_q;
    y_d     = v_cnt_q;
    fs_d    = origin;
  end

  // State and output registers.
  always_ff @(posedge pix_clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      mode_q  <= '0;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      pix_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      mode_q  <= mode_d;
      rgb_q   <= rgb_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      pix_q   <= pix_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
    end
  end

  assign vid.de          = de_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.rgb         = pix_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.frame_start = fs_q;

endmodule
